// File: rtl/slice_gather_rx.sv
// Slice gatherer: assembles SLICE_W-wide slices into a WORD_W bus, with early-terminated partial words.
// Optional build macro SLICE_GATHER_RX_MSB_FIRST_EN places slice 0 in the top slot instead of the bottom.
module slice_gather_rx #(
  parameter int WORD_W  = 4,
  parameter int SLICE_W = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [SLICE_W-1:0]                        in_slice,
  input  logic                                      in_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [WORD_W-1:0]                         out_bus,
  output logic [$clog2(WORD_W/SLICE_W):0]           out_count
);

  localparam int N     = WORD_W / SLICE_W;
  localparam int CNT_W = $clog2(N);
  localparam int CW    = CNT_W + 1;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CW-1:0]    WCNT_ONE  = CW'(1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   acc;
  logic [CW-1:0]       acc_count;

  logic [WORD_W-1:0]   merged;
  logic                slice_final;
  logic                out_free;
  logic                take;

  // Position a slice inside an otherwise zero word according to its slot index.
  function automatic logic [WORD_W-1:0] place(input logic [SLICE_W-1:0] s,
                                              input logic [CNT_W-1:0]   k);
    logic [WORD_W-1:0] w;
    w = {{(WORD_W-SLICE_W){1'b0}}, s};
`ifdef SLICE_GATHER_RX_MSB_FIRST_EN
    return w << ((N - 1 - int'(k)) * SLICE_W);
`else
    return w << (int'(k) * SLICE_W);
`endif
  endfunction

  assign merged      = acc | place(in_slice, cnt);
  assign slice_final = (cnt == LAST_SLOT) || in_last;
  assign out_free    = !out_valid || out_ready;
  assign take        = (state == FILL) && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      in_ready  <= 1'b1;
      cnt       <= '0;
      acc       <= '0;
      acc_count <= '0;
      out_valid <= 1'b0;
      out_bus   <= '0;
      out_count <= '0;
    end else begin
      // A consumed word drops valid unless a new word is loaded below in the same cycle.
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      case (state)
        FILL: begin
          if (take) begin
            if (slice_final) begin
              if (out_free) begin
                out_bus   <= merged;
                out_count <= {1'b0, cnt} + WCNT_ONE;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
              end else begin
                acc       <= merged;
                acc_count <= {1'b0, cnt} + WCNT_ONE;
                state     <= HOLD;
                in_ready  <= 1'b0;
              end
            end else begin
              acc <= merged;
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        HOLD: begin
          if (out_free) begin
            out_bus   <= acc;
            out_count <= acc_count;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= FILL;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= FILL;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_gather_rx.sv
// Directed bench for slice_gather_rx (WORD_W=4, SLICE_W=2); expectations follow SLICE_GATHER_RX_MSB_FIRST_EN.
module tb_slice_gather_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_slice;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bus;
  logic [1:0] out_count;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef SLICE_GATHER_RX_MSB_FIRST_EN
  localparam logic [3:0] E_FULL = 4'b0110;
  localparam logic [3:0] E_P11  = 4'b1100;
  localparam logic [3:0] E_P10  = 4'b1000;
  localparam logic [1:0] S9A = 2'b10, S9B = 2'b01, S6A = 2'b01, S6B = 2'b10;
  localparam logic [3:0] E_REPL = 4'b1110;
  localparam logic [3:0] E_RST  = 4'b0100;
  logic [3:0] e_stream [4] = '{4'h3, 4'hA, 4'hC, 4'h5};
`else
  localparam logic [3:0] E_FULL = 4'b1001;
  localparam logic [3:0] E_P11  = 4'b0011;
  localparam logic [3:0] E_P10  = 4'b0010;
  localparam logic [1:0] S9A = 2'b01, S9B = 2'b10, S6A = 2'b10, S6B = 2'b01;
  localparam logic [3:0] E_REPL = 4'b1011;
  localparam logic [3:0] E_RST  = 4'b0001;
  logic [3:0] e_stream [4] = '{4'hC, 4'hA, 4'h3, 4'h5};
`endif
  logic [1:0] s_stream [8] = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b01};

  slice_gather_rx #(.WORD_W(4), .SLICE_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_slice  (in_slice),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic l);
    int t;
    in_valid = 1'b1;
    in_slice = s;
    in_last  = l;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) check("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_slice = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_bus",   out_bus,   0);
    check("rst_count", out_count, 0);
    check("rst_ready", in_ready,  1);
    rst = 1'b0;
    tick();

    // full word
    out_ready = 1'b1;
    send(2'b01, 1'b0);
    check("full_novalid_mid", out_valid, 0);
    send(2'b10, 1'b0);
    check("full_valid", out_valid, 1);
    check("full_bus",   out_bus,   E_FULL);
    check("full_count", out_count, 2);
    tick();
    check("full_drop_valid", out_valid, 0);
    check("full_bus_kept",   out_bus,   E_FULL);

    // partial words, each restarting at slot 0
    send(2'b11, 1'b1);
    check("part_valid", out_valid, 1);
    check("part_bus",   out_bus,   E_P11);
    check("part_count", out_count, 1);
    send(2'b10, 1'b1);
    check("part2_bus",   out_bus,   E_P10);
    check("part2_count", out_count, 1);
    tick();

    // backpressure into HOLD
    out_ready = 1'b0;
    send(S9A, 1'b0);
    send(S9B, 1'b0);
    check("bp_w1_bus", out_bus, 4'h9);
    send(S6A, 1'b0);
    check("bp_ready_mid", in_ready, 1);
    send(S6B, 1'b0);
    check("bp_hold_ready", in_ready, 0);
    tick();
    check("bp_stable_bus",   out_bus,   4'h9);
    check("bp_stable_valid", out_valid, 1);
    check("bp_stable_count", out_count, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_w2_bus",   out_bus,   4'h6);
    check("bp_w2_valid", out_valid, 1);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_w2_stable", out_bus, 4'h6);

    // same-cycle replace: final slice while the consumer takes the old word
    send(2'b11, 1'b0);
    check("repl_old_bus", out_bus, 4'h6);
    out_ready = 1'b1;
    send(2'b10, 1'b0);
    check("repl_valid", out_valid, 1);
    check("repl_bus",   out_bus,   E_REPL);
    check("repl_count", out_count, 2);

    // streaming
    for (int i = 0; i < 8; i++) begin
      send(s_stream[i], 1'b0);
      if (i == 7) out_ready = 1'b0;
      check($sformatf("stream_ready_%0d", i), in_ready, 1);
      if (i % 2 == 1) begin
        check($sformatf("stream_valid_%0d", i), out_valid, 1);
        check($sformatf("stream_bus_%0d", i), out_bus, e_stream[i/2]);
        check($sformatf("stream_count_%0d", i), out_count, 2);
      end
    end

    // reset mid-word
    send(2'b11, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_bus",   out_bus,   0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_ready", in_ready,  1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    send(2'b01, 1'b0);
    send(2'b00, 1'b0);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_bus",   out_bus,   E_RST);
    check("post_rst_count", out_count, 2);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
